mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS core.
- Decodes the 6-bit opcode and sequences the datapath with Moore-style control strobes.
- Drives `alu_op` (type `alu_op_t` from MIPS_Generic_Definitions.pkg) into the ALU decoder; this block produces the op that the ALU decoder consumes.
- Stalls on a single-port memory through a `mem_ready` handshake.

Parameters:
- MEM_TIMEOUT, default 0: max wait cycles in a memory state; 0 disables the timeout.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction opcode, instr[31:26], from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completed the current read/write this cycle.
- mem_rd  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  0 = PC address, 1 = ALU-out address.
- ir_write  out  1  load instruction register.
- pc_write  out  1  unconditional PC load.
- branch  out  1  PC load if ALU zero (BEQ).
- pc_src  out  2  00 ALU result, 01 ALU-out reg, 10 jump target.
- alu_src_a  out  1  0 = PC, 1 = rs register A.
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  alu_op_t  ADD_Op / SUB_Op / R_Type_Op.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALU-out, 1 = memory data.
- reg_write  out  1  register-file write enable.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal  out  1  sticky fault flag.

Behaviour:
- State register: 4 bits. rst_n low → state = FETCH, wait counter = 0, illegal = 0, asynchronously.
- Outputs are combinational from state plus `mem_ready`.
- Defaults in every state: all enables 0, `pc_src` = 00, `alu_src_a` = 0, `alu_src_b` = 00, `alu_op` = ADD_Op, `reg_dst` = 0, `mem_to_reg` = 0.
- Opcodes: LW 100011, SW 101011, R-type 000000, BEQ 000100, ADDI 001000, J 000010.
- FETCH:
  - Outputs: `mem_rd` = 1, `i_or_d` = 0, `alu_src_b` = 01, ADD_Op; `ir_write` = `pc_write` = `mem_ready`.
  - Transition: `mem_ready` → DECODE; otherwise stay.
- DECODE:
  - Outputs: `alu_src_b` = 11, ADD_Op (precomputes the branch target).
  - Next state: LW/SW → MEM_ADR, R → EXEC, BEQ → BRANCH, ADDI → ADDI_EX, J → JUMP, else → ILLEGAL.
- MEM_ADR: `alu_src_a` = 1, `alu_src_b` = 10, ADD_Op; → MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `mem_rd` = 1, `i_or_d` = 1; wait for `mem_ready` → MEM_WB.
- MEM_WB: `mem_to_reg` = 1, `reg_write` = 1, `instr_done` = 1; → FETCH.
- MEM_WR: `mem_write` = 1, `i_or_d` = 1; `mem_ready` → FETCH with `instr_done` = 1.
- EXEC: `alu_src_a` = 1, `alu_src_b` = 00, R_Type_Op; → ALU_WB.
- ALU_WB: `reg_dst` = 1, `reg_write` = 1, `instr_done` = 1; → FETCH.
- BRANCH: `alu_src_a` = 1, SUB_Op, `branch` = 1, `pc_src` = 01, `instr_done` = 1; → FETCH.
- ADDI_EX: `alu_src_a` = 1, `alu_src_b` = 10, ADD_Op; → ADDI_WB.
- ADDI_WB: `reg_write` = 1, `instr_done` = 1; → FETCH.
- JUMP: `pc_write` = 1, `pc_src` = 10, `instr_done` = 1; → FETCH.
- ILLEGAL: `illegal` = 1, all enables 0; absorbing until reset.
- Latencies (`mem_ready` immediate): LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3 cycles.
- Wait counter:
  - Counts consecutive cycles in FETCH/MEM_RD/MEM_WR with `mem_ready` = 0; cleared on `mem_ready` or state change.
  - If MEM_TIMEOUT > 0 and the count reaches MEM_TIMEOUT → ILLEGAL.
  - Counter saturates; width is $clog2(MEM_TIMEOUT+1), min 1.
- `mem_ready` outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset mid-instruction aborts immediately; no further write strobes are issued after rst_n falls.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined: opcode 000101 decodes to BNE_ST.
  - BNE_ST outputs match BRANCH but assert `branch_ne` = 1 instead of `branch`.
  - Extra output port `branch_ne` (1 bit).
- Undefined: port absent; 000101 → ILLEGAL.

Test Plan:
- Reset + LW, `mem_ready` held 1: states 0→1→2→3→4→0; `reg_write` = 1, `mem_to_reg` = 1 in cycle 5; `instr_done` pulses once.
- SW with `mem_ready` low 3 cycles in MEM_WR: `mem_write` held 4 cycles, `i_or_d` = 1; `instr_done` only on the ready cycle.
- R-type: EXEC drives `alu_op` = R_Type_Op, `alu_src_b` = 00; ALU_WB drives `reg_dst` = 1, `reg_write` = 1; 4-cycle total.
- BEQ then J: BEQ drives SUB_Op, `branch` = 1, `pc_src` = 01; J drives `pc_write` = 1, `pc_src` = 10; both 3 cycles.
- Opcode 111111 → ILLEGAL, `illegal` = 1 persists 10 cycles with no enables; rst_n pulse → FETCH, `illegal` = 0.
- MEM_TIMEOUT = 4, `mem_ready` stuck 0 in FETCH → ILLEGAL after 4 wait cycles.
- rst_n asserted during MEM_WR: `mem_write` drops asynchronously.

Source files
------------

// File: rtl/MIPS_Generic_Definitions.sv
// Shared type definitions for the multicycle MIPS core.
//   alu_op_t : coarse ALU operation from the main control FSM to the ALU
//              decoder (ADD for address/PC math, SUB for branch compare,
//              R_Type_Op to let the funct field decide).
package MIPS_Generic_Definitions;

  typedef enum logic [1:0] {
    ADD_Op    = 2'b00,
    SUB_Op    = 2'b01,
    R_Type_Op = 2'b10
  } alu_op_t;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core. Decodes the opcode and
// sequences the datapath with Moore-style strobes; memory states stall on
// mem_ready. An optional wait timeout (MEM_TIMEOUT > 0) traps a stuck memory
// into ILLEGAL.
//
// Optional feature: define MIPS_CTRL_BNE_EN to decode opcode 000101 as BNE
// (adds output branch_ne). Without it, 000101 is illegal.
//
// Ports:
//   clk, rst_n         core clock, async active-low reset
//   opcode[5:0]        instr[31:26], valid from DECODE onward
//   mem_ready          memory finished the current access this cycle
//   mem_rd, mem_write  memory requests; i_or_d selects PC (0) / ALU-out (1)
//   ir_write, pc_write, branch, pc_src[1:0]   IR / PC update controls
//   alu_src_a, alu_src_b[1:0], alu_op         ALU operand / op selects
//   reg_dst, mem_to_reg, reg_write            register-file write controls
//   instr_done         pulse on the last cycle of each instruction
//   illegal            sticky fault flag (held until reset)
//   branch_ne          BNE PC-load enable (MIPS_CTRL_BNE_EN only)
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC+4 when memory ready
// DECODE  | register read, precompute branch target
// MEM_ADR | compute load/store address
// MEM_RD  | load data read, wait for memory
// MEM_WB  | write load data to rt
// MEM_WR  | store write, wait for memory
// EXEC    | R-type ALU operation
// ALU_WB  | write ALU result to rd
// BRANCH  | BEQ compare and conditional PC load
// ADDI_EX | ADDI add with sign-extended immediate
// ADDI_WB | write ADDI result to rt
// JUMP    | PC <= jump target
// ILLEGAL | bad opcode or memory timeout, absorbing
// BNE_ST  | BNE compare and conditional PC load
module mips_multicycle_ctrl
  import MIPS_Generic_Definitions::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output alu_op_t    alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal
`ifdef MIPS_CTRL_BNE_EN
  ,
  output logic       branch_ne
`endif
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_TO  = CW'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_ADR = 4'd2,
    MEM_RD  = 4'd3,
    MEM_WB  = 4'd4,
    MEM_WR  = 4'd5,
    EXEC    = 4'd6,
    ALU_WB  = 4'd7,
    BRANCH  = 4'd8,
    ADDI_EX = 4'd9,
    ADDI_WB = 4'd10,
    JUMP    = 4'd11,
    ILLEGAL = 4'd12,
    BNE_ST  = 4'd13
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_inc;
  logic          waiting, timeout_hit;

  assign waiting  = ((state == FETCH) || (state == MEM_RD) || (state == MEM_WR)) && !mem_ready;
  assign wait_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CW'(1);
  // Fires on the wait cycle that brings the count up to MEM_TIMEOUT.
  assign timeout_hit = (MEM_TIMEOUT > 0) && waiting && (wait_inc >= CNT_TO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (waiting && (state_nxt == state)) ? wait_inc : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = MEM_ADR;
          OP_R:         state_nxt = EXEC;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDI_EX;
          OP_J:         state_nxt = JUMP;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_nxt = BNE_ST;
`endif
          default:      state_nxt = ILLEGAL;
        endcase
      end
      MEM_ADR: state_nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:  if (mem_ready) state_nxt = MEM_WB;
      MEM_WB:  state_nxt = FETCH;
      MEM_WR:  if (mem_ready) state_nxt = FETCH;
      EXEC:    state_nxt = ALU_WB;
      ALU_WB:  state_nxt = FETCH;
      BRANCH:  state_nxt = FETCH;
      ADDI_EX: state_nxt = ADDI_WB;
      ADDI_WB: state_nxt = FETCH;
      JUMP:    state_nxt = FETCH;
`ifdef MIPS_CTRL_BNE_EN
      BNE_ST:  state_nxt = FETCH;
`endif
      ILLEGAL: state_nxt = ILLEGAL;
      default: state_nxt = ILLEGAL;
    endcase
    if (timeout_hit) state_nxt = ILLEGAL;
  end

  // Outputs are forced idle while rst_n is low so no strobe (including the
  // mem_ready-driven FETCH writes) can escape during reset.
  always_comb begin
    mem_rd     = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ADD_Op;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
    branch_ne  = 1'b0;
`endif
    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_rd    = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE:  alu_src_b = 2'b11;
        MEM_ADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: begin
          mem_rd = 1'b1;
          i_or_d = 1'b1;
        end
        MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = R_Type_Op;
        end
        ALU_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = SUB_Op;
          branch     = 1'b1;
          pc_src     = 2'b01;
          instr_done = 1'b1;
        end
        ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end
`ifdef MIPS_CTRL_BNE_EN
        BNE_ST: begin
          alu_src_a  = 1'b1;
          alu_op     = SUB_Op;
          branch_ne  = 1'b1;
          pc_src     = 2'b01;
          instr_done = 1'b1;
        end
`endif
        ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
